// File: rtl/avr_dmem_bank_ctrl.sv
// Core RAM bus to NBANKS single-port SRAM macros: windowed decode, wait states, read hold
// register and sticky out-of-range flag. Define DMEM_ACCESS_CNT_EN for rd/wr access counters.
module avr_dmem_bank_ctrl #(
  parameter int unsigned ADR_W       = 12,
  parameter int unsigned BASE_ADDR   = 256,
  parameter int unsigned NBANKS      = 2,
  parameter int unsigned BANK_AW     = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                cp2,
  input  logic                ireset,
  input  logic [ADR_W-1:0]    ramadr,
  input  logic                ramre,
  input  logic                ramwe,
  input  logic [7:0]          dbusout,
  output logic [7:0]          dbusin,
  output logic                cpuwait,
  output logic [NBANKS-1:0]   mem_cen,
  output logic                mem_wen,
  output logic [BANK_AW-1:0]  mem_a,
  output logic [7:0]          mem_d,
  input  logic [NBANKS*8-1:0] mem_q,
  output logic                oob_err,
  input  logic                err_clr,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt
);

  localparam logic [ADR_W-1:0] BASE     = ADR_W'(BASE_ADDR);
  localparam logic [ADR_W:0]   WIN_SIZE = (ADR_W+1)'(NBANKS * (2 ** BANK_AW));
  localparam logic [3:0]       WS_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       rd_hold_q;
  logic             oob_q;
  logic [ADR_W-1:0] off, bank;
  logic             above_base, in_win, req, stall, access, rd_access, oob_set;
  logic [7:0]       sel_q;

  assign off        = ramadr - BASE;
  assign bank       = off >> BANK_AW;
  assign above_base = ramadr >= BASE;
  // Extra bit so a window reaching the top of the address space still compares correctly.
  assign in_win     = above_base && ({1'b0, off} < WIN_SIZE);
  assign req        = (ramre | ramwe) & in_win;
  assign oob_set    = (ramre | ramwe) & above_base & ~in_win;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            access = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Simultaneous ramre/ramwe is a write.
  assign rd_access = access & ~ramwe;

  always_comb begin
    sel_q = 8'h00;
    for (int unsigned i = 0; i < NBANKS; i++) begin
      if (bank == ADR_W'(i)) sel_q = mem_q[8*i +: 8];
    end
  end

  always_comb begin
    mem_cen = '1;
    if (access && ireset) begin
      for (int unsigned i = 0; i < NBANKS; i++) begin
        if (bank == ADR_W'(i)) mem_cen[i] = 1'b0;
      end
    end
  end

  // Outputs are forced quiet while reset is held, even if the core keeps strobing.
  always_comb begin
    if (!ireset)                                dbusin = 8'h00;
    else if (rd_access)                         dbusin = sel_q;
    else if (ramre && above_base && !in_win)    dbusin = 8'h00;
    else                                        dbusin = rd_hold_q;
  end

  assign mem_wen = ~(access & ramwe & ireset);
  assign cpuwait = stall & ireset;
  assign mem_a   = off[BANK_AW-1:0];
  assign mem_d   = dbusout;
  assign oob_err = oob_q;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      rd_hold_q <= 8'h00;
      oob_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_access) rd_hold_q <= sel_q;
      if (oob_set)      oob_q <= 1'b1;
      else if (err_clr) oob_q <= 1'b0;
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      rd_cnt_q <= 16'h0000;
      wr_cnt_q <= 16'h0000;
    end else begin
      if (access && !ramwe && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (access && ramwe && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 16'h0000;
  assign wr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_avr_dmem_bank_ctrl.sv
// Bench for avr_dmem_bank_ctrl: a zero-wait-state and a three-wait-state instance, each with
// behavioural SRAM macros, checked against a flat-memory reference model.
module tb_avr_dmem_bank_ctrl;

`ifdef DMEM_ACCESS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  logic        ireset, err_clr;
  logic [11:0] ramadr;
  logic [7:0]  dbusout;

  logic        re0, we0, cw0, wen0, oob0;
  logic [7:0]  dbusin0, a0, d0;
  logic [1:0]  cen0;
  logic [15:0] q0 = '0;
  logic [15:0] rdc0, wrc0;

  logic        re3, we3, cw3, wen3, oob3;
  logic [7:0]  dbusin3, a3, d3;
  logic [1:0]  cen3;
  logic [15:0] q3 = '0;
  logic [15:0] rdc3, wrc3;

  avr_dmem_bank_ctrl u_dut0 (
    .cp2(cp2), .ireset(ireset), .ramadr(ramadr), .ramre(re0), .ramwe(we0),
    .dbusout(dbusout), .dbusin(dbusin0), .cpuwait(cw0), .mem_cen(cen0), .mem_wen(wen0),
    .mem_a(a0), .mem_d(d0), .mem_q(q0), .oob_err(oob0), .err_clr(err_clr),
    .rd_cnt(rdc0), .wr_cnt(wrc0)
  );

  avr_dmem_bank_ctrl #(.WAIT_STATES(3)) u_dut3 (
    .cp2(cp2), .ireset(ireset), .ramadr(ramadr), .ramre(re3), .ramwe(we3),
    .dbusout(dbusout), .dbusin(dbusin3), .cpuwait(cw3), .mem_cen(cen3), .mem_wen(wen3),
    .mem_a(a3), .mem_d(d3), .mem_q(q3), .oob_err(oob3), .err_clr(err_clr),
    .rd_cnt(rdc3), .wr_cnt(wrc3)
  );

  // SRAM macros clocked on inverted cp2, one flat array per instance.
  logic [7:0] sram0 [512] = '{default: 8'h00};
  logic [7:0] sram3 [512] = '{default: 8'h00};

  always @(negedge cp2) begin
    for (int i = 0; i < 2; i++) begin
      if (!cen0[i]) begin
        if (!wen0) sram0[i*256 + int'(a0)] <= d0;
        else       q0[8*i +: 8] <= sram0[i*256 + int'(a0)];
      end
      if (!cen3[i]) begin
        if (!wen3) sram3[i*256 + int'(a3)] <= d3;
        else       q3[8*i +: 8] <= sram3[i*256 + int'(a3)];
      end
    end
  end

  // Reference model: index 0 = zero-wait instance, index 1 = three-wait instance.
  logic [7:0] refm [2][512];
  logic [7:0] hold [2];
  bit         oob_m [2];
  int         rdm [2];
  int         wrm [2];
  int         n_checks, n_pass;

  function automatic int ws_of(input int w);
    return (w == 0) ? 0 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      hold[d] = 8'h00; oob_m[d] = 1'b0; rdm[d] = 0; wrm[d] = 0;
    end
  endtask

  task automatic set_strobe(input int w, input logic re, input logic we);
    if (w == 0) begin re0 = re; we0 = we; end
    else        begin re3 = re; we3 = we; end
  endtask

  task automatic sample(input int w, output logic cw, output logic [1:0] cen,
                        output logic wen, output logic [7:0] a, output logic [7:0] rd);
    if (w == 0) begin cw = cw0; cen = cen0; wen = wen0; a = a0; rd = dbusin0; end
    else        begin cw = cw3; cen = cen3; wen = wen3; a = a3; rd = dbusin3; end
  endtask

  // Entered and left at one time unit after a rising edge.
  task automatic do_access(input int w, input logic [11:0] addr, input logic re,
                           input logic we, input logic [7:0] data, input string tag);
    logic cw, wen, above, win, exp_wen, oob_now;
    logic [1:0] cen, exp_cen;
    logic [7:0] a, rd, exp_rd;
    int off, stalls, exp_ws;
    bit stall_cen_ok;
    above  = addr >= 12'd256;
    off    = int'(addr) - 256;
    win    = above && off < 512;
    exp_ws = (win && (re || we)) ? ws_of(w) : 0;
    ramadr = addr; dbusout = data;
    set_strobe(w, re, we);
    stalls = 0; stall_cen_ok = 1'b1;
    cw = 1'b0; cen = 2'b11; wen = 1'b1; a = '0; rd = '0;
    for (int c = 0; c < 20; c++) begin
      #7;
      sample(w, cw, cen, wen, a, rd);
      if (!cw) break;
      stalls++;
      if (cen !== 2'b11) stall_cen_ok = 1'b0;
      @(posedge cp2); #1;
    end
    n_checks++;
    if (stalls !== exp_ws) $display("FAIL %s stall: got %0d want %0d", tag, stalls, exp_ws);
    else n_pass++;
    n_checks++;
    if (!stall_cen_ok) $display("FAIL %s stall_cen: got enable want 2'b11", tag);
    else n_pass++;
    exp_cen = 2'b11;
    if (win && (re || we)) exp_cen[off / 256] = 1'b0;
    n_checks++;
    if (cen !== exp_cen) $display("FAIL %s mem_cen: got %b want %b", tag, cen, exp_cen);
    else n_pass++;
    exp_wen = (win && we) ? 1'b0 : 1'b1;
    n_checks++;
    if (wen !== exp_wen) $display("FAIL %s mem_wen: got %b want %b", tag, wen, exp_wen);
    else n_pass++;
    if (win) begin
      n_checks++;
      if (a !== 8'(off % 256)) $display("FAIL %s mem_a: got %h want %h", tag, a, 8'(off % 256));
      else n_pass++;
    end
    if (re && !we) begin
      exp_rd = win ? refm[w][off] : (above ? 8'h00 : hold[w]);
      n_checks++;
      if (rd !== exp_rd) $display("FAIL %s dbusin: got %h want %h", tag, rd, exp_rd);
      else n_pass++;
    end
    if (win && we) begin
      refm[w][off] = data;
      if (wrm[w] < 65535) wrm[w]++;
    end else if (win && re) begin
      hold[w] = refm[w][off];
      if (rdm[w] < 65535) rdm[w]++;
    end
    for (int d = 0; d < 2; d++) begin
      if (d == w && (re || we) && above && !win) oob_m[d] = 1'b1;
      else if (err_clr) oob_m[d] = 1'b0;
    end
    @(posedge cp2); #1;
    oob_now = (w == 0) ? oob0 : oob3;
    n_checks++;
    if (oob_now !== oob_m[w]) $display("FAIL %s oob_err: got %b want %b", tag, oob_now, oob_m[w]);
    else n_pass++;
    set_strobe(w, 1'b0, 1'b0);
  endtask

  task automatic idle(input int w, input int n);
    logic cw, wen, oob_now;
    logic [1:0] cen;
    logic [7:0] a, rd;
    set_strobe(w, 1'b0, 1'b0);
    repeat (n) begin
      #7;
      sample(w, cw, cen, wen, a, rd);
      n_checks++;
      if (cw !== 1'b0 || cen !== 2'b11 || rd !== hold[w])
        $display("FAIL idle%0d: got cw=%b cen=%b dbusin=%h want 0 11 %h", w, cw, cen, rd, hold[w]);
      else n_pass++;
      @(posedge cp2); #1;
      for (int d = 0; d < 2; d++) if (err_clr) oob_m[d] = 1'b0;
      oob_now = (w == 0) ? oob0 : oob3;
      n_checks++;
      if (oob_now !== oob_m[w]) $display("FAIL idle%0d oob: got %b want %b", w, oob_now, oob_m[w]);
      else n_pass++;
    end
  endtask

  task automatic check_counters(input string tag);
    int exp_r0, exp_w0, exp_r3, exp_w3;
    exp_r0 = CNT_EN ? rdm[0] : 0; exp_w0 = CNT_EN ? wrm[0] : 0;
    exp_r3 = CNT_EN ? rdm[1] : 0; exp_w3 = CNT_EN ? wrm[1] : 0;
    n_checks++;
    if (int'(rdc0) !== exp_r0 || int'(wrc0) !== exp_w0)
      $display("FAIL %s cnt0: got rd=%0d wr=%0d want rd=%0d wr=%0d", tag, rdc0, wrc0, exp_r0, exp_w0);
    else n_pass++;
    n_checks++;
    if (int'(rdc3) !== exp_r3 || int'(wrc3) !== exp_w3)
      $display("FAIL %s cnt3: got rd=%0d wr=%0d want rd=%0d wr=%0d", tag, rdc3, wrc3, exp_r3, exp_w3);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic cw, wen;
    logic [1:0] cen;
    logic [7:0] a, rd;
    ireset = 1'b0; err_clr = 1'b0; ramadr = 12'h100; dbusout = 8'h00;
    re0 = 1'b1; we0 = 1'b0; re3 = 1'b1; we3 = 1'b0;
    model_reset();
    #3;
    for (int w = 0; w < 2; w++) begin
      sample(w, cw, cen, wen, a, rd);
      n_checks++;
      if (cw !== 1'b0 || cen !== 2'b11 || wen !== 1'b1 || rd !== 8'h00)
        $display("FAIL reset%0d: got cw=%b cen=%b wen=%b dbusin=%h want 0 11 1 00", w, cw, cen, wen, rd);
      else n_pass++;
    end
    n_checks++;
    if (oob0 !== 1'b0 || oob3 !== 1'b0) $display("FAIL reset oob: got %b %b want 0 0", oob0, oob3);
    else n_pass++;
    check_counters("reset");
    re0 = 1'b0; re3 = 1'b0;
    @(posedge cp2); #3;
    ireset = 1'b1;
    @(posedge cp2); #1;
  endtask

  task automatic test_basic_rw();
    do_access(0, 12'h100, 1'b0, 1'b1, 8'hA5, "wr100");
    do_access(0, 12'h100, 1'b1, 1'b0, 8'h00, "rd100");
    do_access(0, 12'h2FF, 1'b0, 1'b1, 8'h3C, "wr2ff");
    do_access(0, 12'h2FF, 1'b1, 1'b0, 8'h00, "rd2ff");
    idle(0, 3);
  endtask

  task automatic test_wait_states();
    do_access(1, 12'h180, 1'b0, 1'b1, 8'h5A, "ws_wr180");
    do_access(1, 12'h180, 1'b1, 1'b0, 8'h00, "ws_rd180");
    do_access(1, 12'h27E, 1'b0, 1'b1, 8'hC3, "ws_wr27e");
    do_access(1, 12'h27E, 1'b1, 1'b0, 8'h00, "ws_rd27e");
    idle(1, 2);
  endtask

  task automatic test_oob();
    do_access(0, 12'h300, 1'b1, 1'b0, 8'h00, "oob_rd300");
    idle(0, 3);
    err_clr = 1'b1; idle(0, 1); err_clr = 1'b0;
    err_clr = 1'b1;
    do_access(0, 12'hFFF, 1'b0, 1'b1, 8'h11, "oob_setprio");
    err_clr = 1'b0;
    err_clr = 1'b1; idle(0, 1); err_clr = 1'b0;
    do_access(0, 12'h0FF, 1'b1, 1'b0, 8'h00, "below_base");
    do_access(0, 12'h0FF, 1'b0, 1'b1, 8'h22, "below_base_wr");
  endtask

  task automatic test_abort();
    logic cw, wen;
    logic [1:0] cen;
    logic [7:0] a, rd;
    ramadr = 12'h200;
    set_strobe(1, 1'b1, 1'b0);
    @(posedge cp2); #1;
    set_strobe(1, 1'b0, 1'b0);
    #7;
    sample(1, cw, cen, wen, a, rd);
    n_checks++;
    if (cw !== 1'b0 || cen !== 2'b11) $display("FAIL abort: got cw=%b cen=%b want 0 11", cw, cen);
    else n_pass++;
    @(posedge cp2); #1;
    do_access(1, 12'h200, 1'b1, 1'b0, 8'h00, "after_abort");
  endtask

  task automatic test_reset_midwait();
    logic cw, wen;
    logic [1:0] cen;
    logic [7:0] a, rd;
    ramadr = 12'h180;
    set_strobe(1, 1'b1, 1'b0);
    @(posedge cp2); #3;
    ireset = 1'b0;
    model_reset();
    #1;
    sample(1, cw, cen, wen, a, rd);
    n_checks++;
    if (cw !== 1'b0 || cen !== 2'b11 || wen !== 1'b1 || rd !== 8'h00)
      $display("FAIL midwait_reset: got cw=%b cen=%b wen=%b dbusin=%h want 0 11 1 00", cw, cen, wen, rd);
    else n_pass++;
    set_strobe(1, 1'b0, 1'b0);
    @(posedge cp2); #3;
    ireset = 1'b1;
    @(posedge cp2); #1;
    do_access(1, 12'h180, 1'b1, 1'b0, 8'h00, "post_reset_rd");
  endtask

  task automatic test_counters();
    @(posedge cp2); #3;
    ireset = 1'b0; model_reset();
    #2 ireset = 1'b1;
    @(posedge cp2); #1;
    for (int i = 0; i < 5; i++)
      do_access(0, 12'(12'h110 + 12'(i * 60)), 1'b0, 1'b1, 8'(8'h40 + i), "cnt_wr");
    for (int i = 0; i < 3; i++)
      do_access(0, 12'(12'h110 + 12'(i * 60)), 1'b1, 1'b0, 8'h00, "cnt_rd");
    do_access(0, 12'h350, 1'b1, 1'b0, 8'h00, "cnt_oob");
    check_counters("cnt_5w3r");
    err_clr = 1'b1; idle(0, 1); err_clr = 1'b0;
  endtask

  task automatic test_random(input int w, input int n);
    logic [11:0] addr;
    logic re, we;
    int r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       addr = 12'(256 + $urandom_range(0, 511));
      else if (r == 7) addr = 12'($urandom_range(0, 255));
      else             addr = 12'($urandom_range(768, 4095));
      r = int'($urandom_range(0, 3));
      re = (r != 0); we = (r == 0 || r == 2);
      do_access(w, addr, re, we, 8'($urandom), "rand");
      if ($urandom_range(0, 4) == 0) idle(w, 1);
      if (oob_m[w] && $urandom_range(0, 2) == 0) begin
        err_clr = 1'b1; idle(w, 1); err_clr = 1'b0;
      end
    end
    check_counters("rand");
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 512; i++) refm[d][i] = 8'h00;
    test_reset();
    test_basic_rw();
    test_wait_states();
    test_oob();
    test_abort();
    test_reset_midwait();
    test_counters();
    test_random(0, 60);
    test_random(1, 40);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avr_dmem_bank_ctrl.md
Name: avr_dmem_bank_ctrl

Overview:
Data-memory controller between the avr_core RAM bus (ramadr/ramre/ramwe/dbusout/dbusin) and NBANKS single-port SRAM macros (CEN/WEN/A/D/Q, active-low enables, macros clocked on inverted cp2).
- Generalises the single fixed-window macro hookup: parametrised base address, bank count and bank depth.
- Adds programmable wait states driving core cpuwait, a read-data hold register and a sticky out-of-range flag.

Parameters:
ADR_W, 12, width of core ramadr
BASE_ADDR, 256, first data-memory address; lower addresses belong to regfile/IO and are ignored
NBANKS, 2, number of SRAM macros (1..8)
BANK_AW, 8, address width per macro (depth 2^BANK_AW)
WAIT_STATES, 0, stall cycles per access (0..15)
Constraint: BASE_ADDR + NBANKS*2^BANK_AW <= 2^ADR_W.

Ports:
cp2  in  1  core clock; all flops rising-edge
ireset  in  1  asynchronous active-low reset
ramadr  in  ADR_W  core data address
ramre  in  1  core read strobe
ramwe  in  1  core write strobe
dbusout  in  8  core write data
dbusin  out  8  read data to core
cpuwait  out  1  stall request to core
mem_cen  out  NBANKS  per-macro chip enable, active low
mem_wen  out  1  shared write enable, active low
mem_a  out  BANK_AW  shared macro address
mem_d  out  8  shared macro write data
mem_q  in  NBANKS*8  macro read data, bank i at [8i+7:8i]
oob_err  out  1  sticky out-of-range flag
err_clr  in  1  synchronous clear of oob_err
rd_cnt  out  16  read access counter (optional feature)
wr_cnt  out  16  write access counter (optional feature)

Behaviour:
- Decode: off = ramadr - BASE_ADDR (ADR_W bits). in_win = ramadr >= BASE_ADDR and off < NBANKS*2^BANK_AW. bank = off >> BANK_AW. mem_a = off[BANK_AW-1:0]. mem_d = dbusout, always.
- req = (ramre | ramwe) & in_win. ramre and ramwe both high is treated as a write.
- FSM states: IDLE and WAIT. Counter cnt is 4 bits.
  - IDLE, req, WAIT_STATES>0: cpuwait=1 combinationally; next state WAIT; cnt <= WAIT_STATES-1.
  - WAIT, cnt!=0: cpuwait=1; cnt <= cnt-1.
  - WAIT, cnt==0: cpuwait=0; this is the access cycle; next state IDLE.
  - WAIT and req drops (core aborted): return to IDLE, no macro enable.
- Access cycle is (IDLE & req & WAIT_STATES==0) or (WAIT & cnt==0 & req).
  - mem_cen[bank]=0 only in the access cycle; all other bits 1.
  - mem_wen=0 only in an access cycle with ramwe=1.
  - Stall per access = exactly WAIT_STATES cycles. Back-to-back accesses each stall in full.
- Read data:
  - In a read access cycle, dbusin = mem_q[bank], combinational and valid before the next rising edge.
  - rd_hold <= mem_q[bank] on that edge.
  - Otherwise dbusin = rd_hold.
  - Reads with ramre and ramadr >= BASE_ADDR but not in_win drive dbusin = 8'h00.
- oob_err:
  - Set on any rising edge where (ramre|ramwe) and ramadr >= BASE_ADDR and not in_win. No macro is enabled for such an access.
  - Held until err_clr=1. Set has priority over clear in the same cycle.
- Reset (ireset=0, any time including mid-WAIT): state=IDLE, cnt=0, rd_hold=8'h00, oob_err=0, counters=0.
  - Outputs immediately: cpuwait=0, mem_cen all 1, mem_wen=1, dbusin=8'h00.

Optional Feature:
DMEM_ACCESS_CNT_EN
- Defined: rd_cnt/wr_cnt increment by 1 on each completed read/write access cycle. Each saturates at 16'hFFFF. Cleared only by reset.
- Undefined: rd_cnt and wr_cnt ports remain and are tied to 16'h0000; no counter flops are synthesised.

Test Plan:
- Defaults, write 8'hA5 to 12'h100 then read it: mem_cen=2'b10, mem_wen=0, mem_a=8'h00 in the write cycle; read returns dbusin=8'hA5, cpuwait never high.
- Write 12'h2FF with 8'h3C then read it: mem_cen=2'b01, mem_a=8'hFF, read returns 8'h3C; rd_hold keeps 8'h3C while idle.
- WAIT_STATES=2, read 12'h180: cpuwait high exactly 2 cycles, mem_cen[0]=0 only in the 3rd cycle, data returned in the 3rd cycle.
- Access 12'h300 (out of window, defaults): no mem_cen low, dbusin=8'h00, oob_err=1 and stays set; err_clr pulse -> 0; access 12'h0FF -> oob_err stays 0.
- WAIT_STATES=3, deassert ireset during 2nd wait cycle: cpuwait and all mem_cen deassert immediately; after release, the next access stalls a full 3 cycles.
- DMEM_ACCESS_CNT_EN defined: 5 writes and 3 reads in window plus 1 out of window -> wr_cnt=5, rd_cnt=3; undefined -> both 0.
